// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions a raw pushbutton into a debounced level plus single-clk press,
// release and auto-repeat pulses. All sampling is gated by the tick strobe
// from the divider stage, so every timing parameter is expressed in ticks.
// The button input is synchronized into clk before any other use.

module button_conditioner #(
    parameter int STABLE_TICKS = 4,   // consecutive differing samples to change level
    parameter int REPEAT_DELAY = 50,  // ticks from press to first repeat (0 = off)
    parameter int REPEAT_RATE  = 10   // ticks between later repeats
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    // Number of flops in the input synchronizer chain.
    localparam int SYNC_STAGES = 2;

    // Terminal counts, pre-sized to the 16-bit counters they are compared with.
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_TICKS - 1);
    localparam logic [15:0] DELAY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RATE_LAST   = 16'(REPEAT_RATE - 1);

    // A zero delay turns auto-repeat off entirely; the FSM then parks in
    // HELD_DELAY until the release edge.
    localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        RELEASED,
        HELD_DELAY,
        HELD_REPEAT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_sync;

    // Shift the asynchronous button through the synchronizer chain every clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_sync = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [15:0] deb_cnt_reg;
    logic        btn_level_reg;
    logic        differs;
    logic        deb_done;
    logic        rise_edge;
    logic        fall_edge;

    // The level flips on the tick that completes the run of differing
    // samples; rise/fall are the same-cycle qualifiers used by the pulse
    // registers and the FSM so every output changes on the same clk edge.
    assign differs   = (btn_sync != btn_level_reg);
    assign deb_done  = tick && differs && (deb_cnt_reg == STABLE_LAST);
    assign rise_edge = deb_done && !btn_level_reg;
    assign fall_edge = deb_done &&  btn_level_reg;

    // Count consecutive differing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_reg   <= '0;
            btn_level_reg <= 1'b0;
        end else if (tick) begin
            if (!differs) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == STABLE_LAST) begin
                btn_level_reg <= ~btn_level_reg;
                deb_cnt_reg   <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge pulses
    // ------------------------------------------------------------------
    logic press_pulse_reg;
    logic release_pulse_reg;

    // Register the edge qualifiers so each pulse is high exactly in the
    // first cycle the new level is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
        end else begin
            press_pulse_reg   <= rise_edge;
            release_pulse_reg <= fall_edge;
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat FSM
    // ------------------------------------------------------------------
    state_t      state_reg;
    logic [15:0] rpt_cnt_reg;
    logic        repeat_pulse_reg;

    // Track press/hold/release and time the repeat pulses. The release edge
    // is checked first so it overrides any repeat falling due on that tick,
    // which keeps repeat and release pulses mutually exclusive. A press can
    // only be taken from RELEASED, where no repeat is ever issued, so press
    // and repeat pulses are exclusive as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= RELEASED;
            rpt_cnt_reg      <= '0;
            repeat_pulse_reg <= 1'b0;
        end else begin
            repeat_pulse_reg <= 1'b0;
            if (tick) begin
                if (fall_edge) begin
                    state_reg   <= RELEASED;
                    rpt_cnt_reg <= '0;
                end else begin
                    case (state_reg)
                        RELEASED: begin
                            if (rise_edge) begin
                                state_reg   <= HELD_DELAY;
                                rpt_cnt_reg <= '0;
                            end
                        end
                        HELD_DELAY: begin
                            if (REPEAT_EN) begin
                                if (rpt_cnt_reg == DELAY_LAST) begin
                                    repeat_pulse_reg <= 1'b1;
                                    rpt_cnt_reg      <= '0;
                                    state_reg        <= HELD_REPEAT;
                                end else begin
                                    rpt_cnt_reg <= rpt_cnt_reg + 16'd1;
                                end
                            end
                        end
                        HELD_REPEAT: begin
                            if (rpt_cnt_reg == RATE_LAST) begin
                                repeat_pulse_reg <= 1'b1;
                                rpt_cnt_reg      <= '0;
                            end else begin
                                rpt_cnt_reg <= rpt_cnt_reg + 16'd1;
                            end
                        end
                        default: begin
                            state_reg   <= RELEASED;
                            rpt_cnt_reg <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign btn_level     = btn_level_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
    assign repeat_pulse  = repeat_pulse_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with STABLE_TICKS=3, REPEAT_DELAY=4,
// REPEAT_RATE=2 and a tick on every 4th clk. The stimulus process pushes
// the hand-computed (pulse kind, tick index) of every expected pulse into a
// queue; the monitor pops one entry for each pulse the DUT presents.

module tb_button_conditioner;

    localparam int ST = 3;
    localparam int RD = 4;
    localparam int RR = 2;

    localparam logic [2:0] K_PRESS   = 3'b100;
    localparam logic [2:0] K_RELEASE = 3'b010;
    localparam logic [2:0] K_REPEAT  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        int         at_tick;
    } exp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic tick   = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    int   compared   = 0;
    int   mismatched = 0;
    int   tick_idx   = 0;
    exp_t exp_q[$];

    button_conditioner #(
        .STABLE_TICKS (ST),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [2:0] k, input int t);
        exp_t e;
        e.kind    = k;
        e.at_tick = t;
        exp_q.push_back(e);
    endtask

    // One tick period: btn_in set just after the previous tick, three idle
    // clks (two of which fill the synchronizer), then the tick clk.
    task automatic do_tick(input logic b);
        @(negedge clk);
        btn_in = b;
        tick   = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        tick = 1'b1;
        tick_idx++;
    endtask

    task automatic ticks(input logic b, input int n);
        for (int i = 0; i < n; i++) do_tick(b);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_btn_level"},     int'(btn_level),     0);
        check({tag, "_press_pulse"},   int'(press_pulse),   0);
        check({tag, "_release_pulse"}, int'(release_pulse), 0);
        check({tag, "_repeat_pulse"},  int'(repeat_pulse),  0);
    endtask

    // Monitor: sample 1 ns after each rising edge and match every pulse.
    initial begin
        logic [2:0] k;
        exp_t       e;
        forever begin
            @(posedge clk);
            #1;
            k = {press_pulse, release_pulse, repeat_pulse};
            if (k != 3'b000) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_pulse: got kind %b at tick %0d, required no pulse", k, tick_idx);
                end else begin
                    e = exp_q.pop_front();
                    $display("pulse kind %b at tick %0d (expected kind %b at tick %0d)",
                             k, tick_idx, e.kind, e.at_tick);
                    check("pulse_kind", int'(k), int'(e.kind));
                    check("pulse_tick", tick_idx, e.at_tick);
                    if (e.kind == K_PRESS)   check("level_at_press",   int'(btn_level), 1);
                    if (e.kind == K_RELEASE) check("level_at_release", int'(btn_level), 0);
                end
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int p;
        int r;

        // Power-on reset, checked without waiting for a clk edge.
        #2 rst = 1'b1;
        #1;
        check_all_zero("por");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ticks(1'b0, 2);

        // Clean press, auto-repeat, then a release that lands on a due repeat.
        p = tick_idx + 3;
        expect_evt(K_PRESS, p);
        for (int i = RD; i <= 18; i += RR) expect_evt(K_REPEAT, p + i);
        expect_evt(K_RELEASE, p + 20);
        ticks(1'b1, 3);
        ticks(1'b1, 17);
        ticks(1'b0, 3);
        ticks(1'b0, 2);

        // Bounce 1,1,0,1,1,1: press only on the 6th tick; short hold, release.
        p = tick_idx + 6;
        expect_evt(K_PRESS, p);
        expect_evt(K_REPEAT, p + 4);
        expect_evt(K_RELEASE, p + 5);
        do_tick(1'b1);
        do_tick(1'b1);
        do_tick(1'b0);
        do_tick(1'b1);
        do_tick(1'b1);
        do_tick(1'b1);
        ticks(1'b1, 2);
        ticks(1'b0, 3);
        ticks(1'b0, 2);

        // Reset at hold tick 3 (repeat would be due on the next tick).
        p = tick_idx + 3;
        expect_evt(K_PRESS, p);
        ticks(1'b1, 3);
        ticks(1'b1, 3);
        @(posedge clk);
        #3;
        check("level_before_rst", int'(btn_level), 1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_hold_rst");
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Button still held: a fresh press after 3 ticks, then a release.
        r = tick_idx;
        expect_evt(K_PRESS, r + 3);
        expect_evt(K_RELEASE, r + 6);
        ticks(1'b1, 3);
        ticks(1'b0, 3);
        ticks(1'b0, 4);

        repeat (8) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
